// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: constants and helpers that are shared by the memory-access stage
// and its byte sequencer.
//   - Register address and data bus types (RegAddrBus / RegBus).
//   - The reset-active level.
//   - memop encodings.
//   - FSM state codes.
//   - Decode helpers for access size and direction.
package mem_stage_pkg;

  typedef logic [4:0]  reg_addr_bus_t;  // RegAddrBus
  typedef logic [31:0] reg_bus_t;       // RegBus
  typedef logic [3:0]  memop_t;

  localparam logic RST_ACTIVE = 1'b0;

  localparam memop_t MEMOP_NONE = 4'd0;
  localparam memop_t MEMOP_LB   = 4'd1;
  localparam memop_t MEMOP_LH   = 4'd2;
  localparam memop_t MEMOP_LW   = 4'd3;
  localparam memop_t MEMOP_LBU  = 4'd4;
  localparam memop_t MEMOP_LHU  = 4'd5;
  localparam memop_t MEMOP_SB   = 4'd6;
  localparam memop_t MEMOP_SH   = 4'd7;
  localparam memop_t MEMOP_SW   = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;

  // Byte count of an access. NONE and undefined codes give 0.
  function automatic logic [2:0] memop_len(input memop_t op);
    case (op)
      MEMOP_NONE:                     memop_len = 3'd0;
      MEMOP_LB, MEMOP_LBU, MEMOP_SB:  memop_len = 3'd1;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH:  memop_len = 3'd2;
      MEMOP_LW, MEMOP_SW:             memop_len = 3'd4;
      default:                        memop_len = 3'd0;
    endcase
  endfunction

  function automatic logic memop_is_load(input memop_t op);
    memop_is_load = (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
                    (op == MEMOP_LBU) || (op == MEMOP_LHU);
  endfunction

  function automatic logic memop_is_store(input memop_t op);
    memop_is_store = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

endpackage

// File: rtl/ram_byte_seq.sv
// ram_byte_seq: counter-based byte sequencer for the 8-bit RAM port.
//   Inputs:
//     clk, rst     - clock; asynchronous active-low reset.
//     start        - begin an access.
//     wr_in        - access direction: 1 = write, 0 = read.
//     len          - byte count N (1, 2 or 4).
//     addr         - start byte address.
//     wdata        - store data.
//     ram_din      - RAM read byte.
//   Outputs:
//     ram_a, ram_wr, ram_dout - RAM port.
//     rdata        - assembled read word, including the byte being captured this
//                    cycle.
//     done         - pulses in the last cycle of the access.
//   Reads: the byte for the address issued in cycle k returns on ram_din in cycle
//   k+1, where it is merged into the assemble register.
module ram_byte_seq
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_in,
  input  logic [2:0]            len,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [7:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  output logic [31:0]           rdata,
  output logic                  done
);

  logic [2:0]            rem_q, rem_d;       // address cycles still to issue
  logic                  wr_q, wr_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [2:0]            len_q, len_d;
  logic [1:0]            idx_q, idx_d;        // index of the byte being issued
  logic [1:0]            cap_idx_q, cap_idx_d;

  logic active;
  assign active = (rem_q != 3'd0);

  // Address, strobe and data are gated so they read as 0 whenever nothing is
  // in flight, including right after reset.
  assign ram_a    = active ? addr_q : '0;
  assign ram_wr   = active && wr_q;
  assign ram_dout = (active && wr_q) ? sdata_q[7:0] : 8'h00;

  always_comb begin
    rdata = asm_q;
    rdata[{cap_idx_q, 3'b000} +: 8] = ram_din;
  end

  assign done = wr_q ? (rem_q == 3'd1)
                     : (cap_vld_q && ({1'b0, cap_idx_q} == (len_q - 3'd1)));

  always_comb begin
    rem_d     = rem_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cap_vld_d = active && !wr_q;
    cap_idx_d = idx_q;
    asm_d     = asm_q;
    if (cap_vld_q) begin
      asm_d[{cap_idx_q, 3'b000} +: 8] = ram_din;
    end
    if (start) begin
      rem_d   = len;
      wr_d    = wr_in;
      addr_d  = addr;
      sdata_d = wdata;
      len_d   = len;
      idx_d   = 2'd0;
      asm_d   = '0;
    end else if (active) begin
      rem_d   = rem_q - 3'd1;
      addr_d  = addr_q + 1'b1;
      sdata_d = {8'h00, sdata_q[31:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      rem_q     <= 3'd0;
      wr_q      <= 1'b0;
      cap_vld_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      wr_q      <= wr_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    sdata_q   <= sdata_d;
    asm_q     <= asm_d;
    len_q     <= len_d;
    idx_q     <= idx_d;
    cap_idx_q <= cap_idx_d;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RISC-V pipeline. It feeds the MEM/WB
// register.
//   Inputs:
//     clk, rst - clock; asynchronous active-low reset.
//     ex_*     - operation from EX/MEM. It is accepted when ex_valid and
//                mem_ready are both 1.
//     ram_din  - RAM read byte, valid one cycle after its address.
//   Outputs:
//     mem_ready / stall_req - stage can accept / pipeline must hold.
//     mem_wd, mem_wreg, mem_wdata - result to MEM/WB. All three are 0 when no
//                result is presented.
//     ram_a, ram_dout, ram_wr - byte-serial RAM port.
//   Optional feature MEM_FWD_EN adds five outputs:
//     fwd_wreg, fwd_wd, fwd_wdata - copies of the MEM/WB outputs, for forwarding
//                into ID.
//     fwd_pending, fwd_pending_wd - an in-flight load and its destination
//                register, for load-use hazard detection.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_memop,
  input  logic [4:0]            ex_wd,
  input  logic                  ex_wreg,
  input  logic [31:0]           ex_wdata,
  input  logic [ADDR_WIDTH-1:0] ex_maddr,
  input  logic [31:0]           ex_sdata,
  output logic                  mem_ready,
  output logic                  stall_req,
  output logic [4:0]            mem_wd,
  output logic                  mem_wreg,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din
`ifdef MEM_FWD_EN
  ,
  output logic                  fwd_wreg,
  output logic [4:0]            fwd_wd,
  output logic [31:0]           fwd_wdata,
  output logic                  fwd_pending,
  output logic [4:0]            fwd_pending_wd
`endif
);

  logic [1:0]    state_q, state_d;
  memop_t        op_q, op_d;
  reg_addr_bus_t op_wd_q, op_wd_d;
  logic          op_wreg_q, op_wreg_d;
  reg_addr_bus_t mem_wd_q, mem_wd_d;
  logic          mem_wreg_q, mem_wreg_d;
  reg_bus_t      mem_wdata_q, mem_wdata_d;

  logic          accept;
  logic          seq_start, seq_wr, seq_done;
  logic [2:0]    seq_len;
  logic [31:0]    seq_rdata;

  function automatic reg_bus_t load_extend(input reg_bus_t d, input memop_t op);
    case (op)
      MEMOP_LB:  load_extend = {{24{d[7]}}, d[7:0]};
      MEMOP_LH:  load_extend = {{16{d[15]}}, d[15:0]};
      MEMOP_LBU: load_extend = {24'h0, d[7:0]};
      MEMOP_LHU: load_extend = {16'h0, d[15:0]};
      default:   load_extend = d;
    endcase
  endfunction

  assign mem_ready = (state_q == ST_IDLE);
  assign stall_req = !mem_ready;
  assign accept    = ex_valid && mem_ready;
  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;
  assign seq_len   = memop_len(ex_memop);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    op_wd_d     = op_wd_q;
    op_wreg_d   = op_wreg_q;
    mem_wd_d    = '0;
    mem_wreg_d  = 1'b0;
    mem_wdata_d = '0;
    seq_start   = 1'b0;
    seq_wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = ex_memop;
          op_wd_d   = ex_wd;
          op_wreg_d = ex_wreg;
          if (memop_is_load(ex_memop)) begin
            state_d   = ST_LOAD;
            seq_start = 1'b1;
          end else if (memop_is_store(ex_memop)) begin
            state_d   = ST_STORE;
            seq_start = 1'b1;
            seq_wr    = 1'b1;
          end else begin
            mem_wd_d    = ex_wd;
            mem_wreg_d  = ex_wreg;
            mem_wdata_d = ex_wdata;
          end
        end
      end
      ST_LOAD: begin
        // done coincides with capture of the last byte; rdata already holds it.
        if (seq_done) begin
          state_d     = ST_IDLE;
          mem_wd_d    = op_wd_q;
          mem_wreg_d  = op_wreg_q;
          mem_wdata_d = load_extend(seq_rdata, op_q);
        end
      end
      ST_STORE: begin
        if (seq_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_IDLE;
      mem_wd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    op_wd_q   <= op_wd_d;
    op_wreg_q <= op_wreg_d;
  end

  ram_byte_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .wr_in    (seq_wr),
    .len      (seq_len),
    .addr     (ex_maddr),
    .wdata    (ex_sdata),
    .ram_din  (ram_din),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .rdata    (seq_rdata),
    .done     (seq_done)
  );

`ifdef MEM_FWD_EN
  assign fwd_wreg       = mem_wreg_q;
  assign fwd_wd         = mem_wd_q;
  assign fwd_wdata      = mem_wdata_q;
  assign fwd_pending    = (state_q == ST_LOAD) && op_wreg_q;
  assign fwd_pending_wd = fwd_pending ? op_wd_q : 5'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_memop;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_maddr;
  logic [31:0] ex_sdata;
  logic        mem_ready;
  logic        stall_req;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
`ifdef MEM_FWD_EN
  logic        fwd_wreg;
  logic [4:0]  fwd_wd;
  logic [31:0] fwd_wdata;
  logic        fwd_pending;
  logic [4:0]  fwd_pending_wd;
`endif

  int checks = 0;
  int failures = 0;

  // RAM model: 4 KiB window on ram_a[11:0], read data one cycle after address.
  logic [7:0] ram [0:4095];
  logic       preload;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      ram[12'h100] <= 8'h78;
      ram[12'h101] <= 8'h56;
      ram[12'h102] <= 8'h34;
      ram[12'h103] <= 8'h12;
      ram[12'h203] <= 8'h80;
      ram[12'h301] <= 8'h01;
      ram[12'h302] <= 8'h90;
      ram[12'h400] <= 8'h00;
      ram[12'h401] <= 8'h00;
      ram[12'h402] <= 8'h00;
      ram[12'h403] <= 8'h00;
      ram[12'h000] <= 8'h00;
      ram[12'h001] <= 8'h11;
      ram[12'hFFF] <= 8'h00;
    end else if (ram_wr) begin
      ram[ram_a[11:0]] <= ram_dout;
    end
    ram_din <= ram[ram_a[11:0]];
  end

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_memop  (ex_memop),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_maddr  (ex_maddr),
    .ex_sdata  (ex_sdata),
    .mem_ready (mem_ready),
    .stall_req (stall_req),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
`ifdef MEM_FWD_EN
    ,
    .fwd_wreg       (fwd_wreg),
    .fwd_wd         (fwd_wd),
    .fwd_wdata      (fwd_wdata),
    .fwd_pending    (fwd_pending),
    .fwd_pending_wd (fwd_pending_wd)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for a single acceptance edge; returns in C1.
  task automatic accept(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] maddr,
                        input logic [31:0] sdata);
    ex_valid = 1'b1;
    ex_memop = op;
    ex_wd    = wd;
    ex_wreg  = wreg;
    ex_wdata = wdata;
    ex_maddr = maddr;
    ex_sdata = sdata;
    tick();
    ex_valid = 1'b0;
    ex_memop = MEMOP_NONE;
  endtask

  initial begin
    rst      = 1'b0;
    preload  = 1'b1;
    ex_valid = 1'b0;
    ex_memop = MEMOP_NONE;
    ex_wd    = 5'd0;
    ex_wreg  = 1'b0;
    ex_wdata = 32'h0;
    ex_maddr = 32'h0;
    ex_sdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;

    chk("rst_ready", mem_ready, 1);
    chk("rst_stall", stall_req, 0);
    chk("rst_wd", mem_wd, 0);
    chk("rst_wreg", mem_wreg, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_dout", ram_dout, 0);
`ifdef MEM_FWD_EN
    chk("rst_fwd_pending", fwd_pending, 0);
    chk("rst_fwd_pending_wd", fwd_pending_wd, 0);
    chk("rst_fwd_wreg", fwd_wreg, 0);
`endif
    rst = 1'b1;
    tick();

    // Back-to-back pass-through, then an idle bubble.
    ex_valid = 1'b1; ex_memop = MEMOP_NONE; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
    tick();
    chk("pt1_wd", mem_wd, 5);
    chk("pt1_wreg", mem_wreg, 1);
    chk("pt1_wdata", mem_wdata, 32'h1234);
    chk("pt1_stall", stall_req, 0);
    ex_memop = 4'd15; ex_wd = 5'd6; ex_wreg = 1'b0; ex_wdata = 32'hBEEF;
    tick();
    ex_valid = 1'b0;
    chk("pt2_wd", mem_wd, 6);
    chk("pt2_wreg", mem_wreg, 0);
    chk("pt2_wdata", mem_wdata, 32'hBEEF);
    chk("pt2_stall", stall_req, 0);
    tick();
    chk("idle_wd", mem_wd, 0);
    chk("idle_wdata", mem_wdata, 0);

    // LW x7 from 0x100.
    accept(MEMOP_LW, 5'd7, 1'b1, 32'hDEAD, 32'h100, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        chk($sformatf("lw_ram_a_c%0d", k + 1), ram_a, 32'h100 + k);
        chk($sformatf("lw_ram_wr_c%0d", k + 1), ram_wr, 0);
      end
      chk($sformatf("lw_stall_c%0d", k + 1), stall_req, 1);
      chk($sformatf("lw_wreg_c%0d", k + 1), mem_wreg, 0);
      chk($sformatf("lw_wdata_c%0d", k + 1), mem_wdata, 0);
`ifdef MEM_FWD_EN
      chk($sformatf("lw_fwd_pending_c%0d", k + 1), fwd_pending, 1);
      chk($sformatf("lw_fwd_pending_wd_c%0d", k + 1), fwd_pending_wd, 7);
`endif
      tick();
    end
    chk("lw_result", mem_wdata, 32'h12345678);
    chk("lw_wd", mem_wd, 7);
    chk("lw_wreg", mem_wreg, 1);
    chk("lw_ready_c6", mem_ready, 1);
`ifdef MEM_FWD_EN
    chk("lw_fwd_pending_c6", fwd_pending, 0);
    chk("lw_fwd_pending_wd_c6", fwd_pending_wd, 0);
    chk("lw_fwd_wd", fwd_wd, 7);
    chk("lw_fwd_wdata", fwd_wdata, 32'h12345678);
`endif
    tick();

    // LB / LBU from 0x203 (byte 0x80).
    accept(MEMOP_LB, 5'd9, 1'b1, 32'h0, 32'h203, 32'h0);
    chk("lb_ram_a", ram_a, 32'h203);
    chk("lb_stall_c1", stall_req, 1);
    tick();
    chk("lb_stall_c2", stall_req, 1);
    tick();
    chk("lb_result", mem_wdata, 32'hFFFFFF80);
    chk("lb_wd", mem_wd, 9);
    chk("lb_stall_c3", stall_req, 0);
    tick();
    accept(MEMOP_LBU, 5'd10, 1'b1, 32'h0, 32'h203, 32'h0);
    tick();
    tick();
    chk("lbu_result", mem_wdata, 32'h00000080);

    // Misaligned LH from 0x301 (bytes 0x01, 0x90).
    tick();
    accept(MEMOP_LH, 5'd11, 1'b1, 32'h0, 32'h301, 32'h0);
    chk("lh_ram_a_c1", ram_a, 32'h301);
    tick();
    chk("lh_ram_a_c2", ram_a, 32'h302);
    tick();
    chk("lh_stall_c3", stall_req, 1);
    tick();
    chk("lh_result", mem_wdata, 32'hFFFF9001);
    tick();

    // SH to 0xFFFFFFFF wraps to 0x0.
    accept(MEMOP_SH, 5'd4, 1'b1, 32'h77, 32'hFFFFFFFF, 32'h5555ABCD);
    chk("sh_ram_a_c1", ram_a, 32'hFFFFFFFF);
    chk("sh_ram_wr_c1", ram_wr, 1);
    chk("sh_dout_c1", ram_dout, 8'hCD);
    chk("sh_stall_c1", stall_req, 1);
    tick();
    chk("sh_ram_a_c2", ram_a, 32'h0);
    chk("sh_ram_wr_c2", ram_wr, 1);
    chk("sh_dout_c2", ram_dout, 8'hAB);
    tick();
    chk("sh_ready_c3", mem_ready, 1);
    chk("sh_wreg_c3", mem_wreg, 0);
    chk("sh_wd_c3", mem_wd, 0);
    chk("sh_ram_wr_c3", ram_wr, 0);
    chk("sh_ram_fff", ram[12'hFFF], 8'hCD);
    chk("sh_ram_000", ram[12'h000], 8'hAB);
    chk("sh_ram_001", ram[12'h001], 8'h11);
    tick();

    // Reset in C2 of an SW to 0x400.
    accept(MEMOP_SW, 5'd0, 1'b0, 32'h0, 32'h400, 32'hDDCCBBAA);
    chk("sw_ram_wr_c1", ram_wr, 1);
    chk("sw_dout_c1", ram_dout, 8'hAA);
    tick();
    chk("sw_ram_a_c2", ram_a, 32'h401);
    rst = 1'b0;
    #1;
    chk("swrst_ram_wr", ram_wr, 0);
    chk("swrst_ram_a", ram_a, 0);
    chk("swrst_dout", ram_dout, 0);
    chk("swrst_ready", mem_ready, 1);
    chk("swrst_stall", stall_req, 0);
    chk("swrst_wdata", mem_wdata, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("swpost_ram_wr_%0d", k), ram_wr, 0);
      tick();
    end
    chk("sw_ram_400", ram[12'h400], 8'hAA);
    chk("sw_ram_401", ram[12'h401], 8'h00);
    chk("sw_ram_402", ram[12'h402], 8'h00);

    // Next op after reset runs normally.
    accept(MEMOP_LW, 5'd2, 1'b1, 32'h0, 32'h400, 32'h0);
    repeat (5) tick();
    chk("post_lw_result", mem_wdata, 32'h000000AA);
    chk("post_lw_wd", mem_wd, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
